// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared external 4-bit ALU.
// Optional macro ALU_ARBITER_LOCK_EN adds lock0/lock1 to pin round-robin priority.
module alu_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic [1:0] sel0,
  input  logic [1:0] sel1,
`ifdef ALU_ARBITER_LOCK_EN
  input  logic       lock0,
  input  logic       lock1,
`endif
  output logic       gnt0,
  output logic       gnt1,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [3:0] alu_y,
  input  logic       alu_k,
  input  logic       alu_n,
  input  logic       alu_c,
  input  logic       alu_v,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [3:0] rsp_y,
  output logic [3:0] rsp_flags,
  output logic       busy
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t     state_q, state_d;
  logic [3:0] op_a_q, op_a_d;
  logic [3:0] op_b_q, op_b_d;
  logic [1:0] op_sel_q, op_sel_d;
  logic       last_id_q, last_id_d;
  logic       owner_q, owner_d;
  logic [1:0] gnt_q, gnt_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_id_q, rsp_id_d;
  logic [3:0] rsp_y_q, rsp_y_d;
  logic [3:0] rsp_flags_q, rsp_flags_d;

  logic       win_id;
  logic       win_lock;

  // On a tie the requester that did not win last time goes first.
  assign win_id = (req0 && req1) ? ~last_id_q : req1;

`ifdef ALU_ARBITER_LOCK_EN
  assign win_lock = win_id ? lock1 : lock0;
`else
  assign win_lock = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its _d input regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_a_q      <= 4'h0;
      op_b_q      <= 4'h0;
      op_sel_q    <= 2'b00;
      last_id_q   <= 1'b1;
      owner_q     <= 1'b0;
      gnt_q       <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_y_q     <= 4'h0;
      rsp_flags_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_sel_q    <= op_sel_d;
      last_id_q   <= last_id_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  // NOTE: every signal gets a default at the top of the block, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sel_d    = op_sel_q;
    last_id_d   = last_id_q;
    owner_d     = owner_q;
    gnt_d       = 2'b00;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    rsp_flags_d = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          op_a_d    = win_id ? a1 : a0;
          op_b_d    = win_id ? b1 : b0;
          op_sel_d  = win_id ? sel1 : sel0;
          owner_d   = win_id;
          gnt_d     = win_id ? 2'b10 : 2'b01;
          last_id_d = win_lock ? last_id_q : win_id;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = owner_q;
        rsp_y_d     = alu_y;
        rsp_flags_d = {alu_k, alu_n, alu_c, alu_v};
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The ALU sees the operand registers in both states, so it never toggles idly.
  always_comb begin
    busy      = (state_q == EXEC);
    gnt0      = gnt_q[0];
    gnt1      = gnt_q[1];
    alu_a     = op_a_q;
    alu_b     = op_b_q;
    alu_sel   = op_sel_q;
    rsp_valid = rsp_valid_q;
    rsp_id    = rsp_id_q;
    rsp_y     = rsp_y_q;
    rsp_flags = rsp_flags_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural ALU, response scoreboard, per-cycle checker.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic [1:0] sel0, sel1;
`ifdef ALU_ARBITER_LOCK_EN
  logic       lock0, lock1;
`endif
  logic       gnt0, gnt1;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_sel;
  logic [3:0] alu_y;
  logic       alu_k, alu_n, alu_c, alu_v;
  logic       rsp_valid, rsp_id;
  logic [3:0] rsp_y, rsp_flags;
  logic       busy;

  typedef struct packed {
    logic       id;
    logic [3:0] y;
    logic [3:0] f;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_gnt = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sel0(sel0), .sel1(sel1),
`ifdef ALU_ARBITER_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .gnt0(gnt0), .gnt1(gnt1), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_y(alu_y), .alu_k(alu_k), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_flags(rsp_flags),
    .busy(busy)
  );

  // Shared ALU: carry is carry-out for add and borrow for subtract.
  always_comb begin : alu_model
    logic [4:0] s;
    s     = 5'h00;
    alu_y = 4'h0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_sel)
      2'b00: begin
        s     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_y = s[3:0];
        alu_c = s[4];
        alu_v = (alu_a[3] == alu_b[3]) && (s[3] != alu_a[3]);
      end
      2'b01: begin
        s     = {1'b0, alu_a} - {1'b0, alu_b};
        alu_y = s[3:0];
        alu_c = s[4];
        alu_v = (alu_a[3] != alu_b[3]) && (s[3] != alu_a[3]);
      end
      2'b10:   alu_y = alu_a & alu_b;
      default: alu_y = alu_a | alu_b;
    endcase
    alu_k = (alu_y == 4'h0);
    alu_n = alu_y[3];
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle checker and scoreboard consumer.
  always @(negedge clk) begin : monitor
    rsp_t e;
    if (rst) begin
      check("rst_quiet", 8'({gnt0, gnt1, busy, rsp_valid}), 8'h00);
      prev_gnt = 1'b0;
    end else begin
      check("gnt_excl", 8'(gnt0 & gnt1), 8'h00);
      check("busy_exec", 8'(busy), 8'(gnt0 | gnt1));
      check("rsp_after_gnt", 8'(rsp_valid), 8'(prev_gnt));
      if (rsp_valid) begin
        check("sb_nonempty", 8'(exp_q.size() != 0), 8'h01);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_id", 8'(rsp_id), 8'(e.id));
          check("rsp_y", 8'(rsp_y), 8'(e.y));
          check("rsp_flags", 8'(rsp_flags), 8'(e.f));
        end
      end
      prev_gnt = gnt0 | gnt1;
    end
  end

  // One request from requester id; ends on the negedge of its response cycle.
  task automatic op(input logic id, input logic [3:0] a, input logic [3:0] b,
                    input logic [1:0] sel, input logic [3:0] ey, input logic [3:0] ef);
    if (id) begin
      req1 = 1'b1; a1 = a; b1 = b; sel1 = sel;
    end else begin
      req0 = 1'b1; a0 = a; b0 = b; sel0 = sel;
    end
    @(negedge clk);
    check("op_gnt0", 8'(gnt0), 8'(!id));
    check("op_gnt1", 8'(gnt1), 8'(id));
    exp_q.push_back(rsp_t'{id: id, y: ey, f: ef});
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
  endtask

  // Both requesters held; seq[i] is the expected winner of grant i.
  task automatic tie_run(input int n, input logic [7:0] seq);
    a0 = 4'h1; b0 = 4'h1; sel0 = 2'b00;
    a1 = 4'h7; b1 = 4'h1; sel1 = 2'b00;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("tie_gnt0", 8'(gnt0), 8'(!seq[i]));
      check("tie_gnt1", 8'(gnt1), 8'(seq[i]));
      exp_q.push_back(rsp_t'{id: seq[i], y: (seq[i] ? 4'h8 : 4'h2), f: (seq[i] ? 4'b0101 : 4'b0000)});
      if (i == n - 1) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 4'h0; b0 = 4'h0; a1 = 4'h0; b1 = 4'h0;
    sel0 = 2'b00; sel1 = 2'b00;
`ifdef ALU_ARBITER_LOCK_EN
    lock0 = 1'b0; lock1 = 1'b0;
`endif
    @(negedge clk);
    check("rst_alu", 8'({alu_a, alu_b} ), 8'h00);
    check("rst_sel_id", 8'({alu_sel, rsp_id}), 8'h00);
    check("rst_rsp", 8'({rsp_y, rsp_flags}), 8'h00);
    #1 rst = 1'b0;

    op(1'b0, 4'h3, 4'h5, 2'b00, 4'h8, 4'b0101);
    op(1'b1, 4'h2, 4'h3, 2'b01, 4'hF, 4'b0110);
    op(1'b1, 4'h5, 4'h5, 2'b01, 4'h0, 4'b1000);
    op(1'b0, 4'hC, 4'hA, 2'b10, 4'h8, 4'b0100);
    op(1'b1, 4'h5, 4'h2, 2'b11, 4'h7, 4'b0000);

    // Response and operand registers hold while idle.
    @(negedge clk);
    check("hold_rsp_y", 8'(rsp_y), 8'h07);
    check("hold_rsp_id", 8'(rsp_id), 8'h01);
    check("hold_flags", 8'(rsp_flags), 8'h00);
    check("hold_alu", 8'({alu_a, alu_b}), 8'h52);
    check("hold_sel", 8'(alu_sel), 8'h03);

    // After reset, a held tie alternates starting with requester 0.
    reset_pulse();
    tie_run(3, 8'b0000_0010);

    // Reset during execution abandons the operation immediately.
    req0 = 1'b1; a0 = 4'h9; b0 = 4'h2; sel0 = 2'b00;
    @(negedge clk);
    check("abort_gnt0", 8'(gnt0), 8'h01);
    req0 = 1'b0;
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_ctl", 8'({gnt0, gnt1, busy, rsp_valid, rsp_id}), 8'h00);
    check("abort_alu", 8'({alu_a, alu_b}), 8'h00);
    check("abort_sel", 8'(alu_sel), 8'h00);
    check("abort_rsp", 8'({rsp_y, rsp_flags}), 8'h00);
    @(negedge clk);
    #1 rst = 1'b0;
    op(1'b1, 4'h4, 4'hC, 2'b10, 4'h4, 4'b0000);

`ifdef ALU_ARBITER_LOCK_EN
    reset_pulse();
    lock0 = 1'b1;
    tie_run(3, 8'b0000_0000);
    lock0 = 1'b0;
    // Locked grants left last_id at 1, so one more gnt0 precedes gnt1.
    tie_run(2, 8'b0000_0010);
`endif

    @(negedge clk);
    check("sb_drained", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
